// File: rtl/cov_engine.sv
// cov_engine: fixed-point sample covariance of X[1..N] and Y[1..N] held in a data memory.
// Define COV_SATURATE_EN to clamp the covariance accumulation instead of wrapping.
module cov_engine #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic [ADDR_W-1:0] MemRdAddr,
    input  logic [DATA_W-1:0] MemRdData,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemWrAddr,
    output logic [DATA_W-1:0] MemWrData
);

    localparam int RES_W = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(RES_W);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ARM   = 4'd1;
    localparam logic [3:0] S_RD_N  = 4'd2;
    localparam logic [3:0] S_ACC_X = 4'd3;
    localparam logic [3:0] S_DIV_X = 4'd4;
    localparam logic [3:0] S_ACC_Y = 4'd5;
    localparam logic [3:0] S_DIV_Y = 4'd6;
    localparam logic [3:0] S_ACC_C = 4'd7;
    localparam logic [3:0] S_DIV_C = 4'd8;
    localparam logic [3:0] S_WR_HI = 4'd9;
    localparam logic [3:0] S_WR_LO = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;

    logic [3:0]        state;
    logic [ADDR_W-1:0] n;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rcv;
    logic [ADDR_W-1:0] rd_addr;
    logic              iss_done;
    logic              phase;
    logic              issue;
    logic              issue_y;
    logic              pend;
    logic              pend_y;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  x_bar;
    logic [RES_W-1:0]  y_bar;
    logic [RES_W-1:0]  dx;
    logic [RES_W-1:0]  result;
    logic [RES_W-1:0]  div_q;
    logic [ADDR_W-1:0] div_rem;
    logic              div_neg;
    logic [CNT_W-1:0]  div_cnt;

    logic [RES_W-1:0]   samp;
    logic [ADDR_W-1:0]  n_in;
    logic [RES_W-1:0]   dy;
    logic [2*RES_W-1:0] prod;
    logic [RES_W-1:0]   term;
    logic [RES_W-1:0]   sum_next;
    logic [RES_W-1:0]   c_next;
    logic [RES_W-1:0]   div_in;
    logic [RES_W-1:0]   div_mag;
    logic [ADDR_W:0]    rem_sh;
    logic               div_bit;
    logic [ADDR_W-1:0]  rem_next;
    logic [RES_W-1:0]   q_next;
    logic [RES_W-1:0]   q_signed;
    logic               div_last;
    logic [ADDR_W-1:0]  wr_base;
`ifdef COV_SATURATE_EN
    logic [RES_W:0]     csum_wide;
`endif

    // NOTE: every combinational output is given a value on every path so no latch is inferred.
    always_comb begin
        samp     = {MemRdData, {FRAC_W{1'b0}}};
        n_in     = ADDR_W'(MemRdData);
        dy       = samp - y_bar;
        prod     = {{RES_W{dx[RES_W-1]}}, dx} * {{RES_W{dy[RES_W-1]}}, dy};
        term     = RES_W'($signed(prod) >>> FRAC_W);
        sum_next = acc + samp;
`ifdef COV_SATURATE_EN
        csum_wide = {acc[RES_W-1], acc} + {term[RES_W-1], term};
        if (csum_wide[RES_W] != csum_wide[RES_W-1])
            c_next = csum_wide[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        else
            c_next = csum_wide[RES_W-1:0];
`else
        c_next = acc + term;
`endif
        // Restoring divide on the magnitude; the sign is reapplied on the last step.
        div_in   = (state == S_ACC_C) ? c_next : sum_next;
        div_mag  = div_in[RES_W-1] ? (~div_in + RES_W'(1)) : div_in;
        rem_sh   = {div_rem, div_q[RES_W-1]};
        div_bit  = (rem_sh >= {1'b0, n});
        rem_next = div_bit ? ADDR_W'(rem_sh - {1'b0, n}) : ADDR_W'(rem_sh);
        q_next   = {div_q[RES_W-2:0], div_bit};
        q_signed = div_neg ? (~q_next + RES_W'(1)) : q_next;
        div_last = (div_cnt == CNT_W'(RES_W - 1));
    end

    always_comb begin
        MemWrEn   = 1'b0;
        MemWrAddr = '0;
        MemWrData = '0;
        wr_base   = n + n;
        case (state)
            S_WR_HI: begin
                MemWrEn   = 1'b1;
                MemWrAddr = wr_base + ADDR_W'(1);
                MemWrData = DATA_W'(result >> DATA_W);
            end
            S_WR_LO: begin
                MemWrEn   = 1'b1;
                MemWrAddr = wr_base + ADDR_W'(2);
                MemWrData = DATA_W'(result);
            end
            default: ;
        endcase
    end

    assign Ack       = (state == S_DONE);
    assign MemRdAddr = rd_addr;

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            n        <= '0;
            idx      <= '0;
            rcv      <= '0;
            rd_addr  <= '0;
            iss_done <= 1'b0;
            phase    <= 1'b0;
            issue    <= 1'b0;
            issue_y  <= 1'b0;
            pend     <= 1'b0;
            pend_y   <= 1'b0;
            acc      <= '0;
            x_bar    <= '0;
            y_bar    <= '0;
            dx       <= '0;
            result   <= '0;
            div_q    <= '0;
            div_rem  <= '0;
            div_neg  <= 1'b0;
            div_cnt  <= '0;
        end else begin
            // Read data returns one cycle after the address; pend marks that cycle.
            issue   <= 1'b0;
            issue_y <= 1'b0;
            pend    <= issue;
            pend_y  <= issue_y;
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) state <= S_ARM;
                end
                S_ARM: begin
                    if (!Start) begin
                        state   <= S_RD_N;
                        rd_addr <= '0;
                        issue   <= 1'b1;
                    end
                end
                S_RD_N: begin
                    if (pend) begin
                        n        <= n_in;
                        acc      <= '0;
                        idx      <= ADDR_W'(1);
                        rcv      <= ADDR_W'(1);
                        iss_done <= 1'b0;
                        phase    <= 1'b0;
                        if (n_in == '0) begin
                            result <= '0;
                            state  <= S_WR_HI;
                        end else begin
                            state  <= S_ACC_X;
                        end
                    end
                end
                S_ACC_X, S_ACC_Y: begin
                    if (!iss_done) begin
                        rd_addr <= (state == S_ACC_Y) ? n + idx : idx;
                        issue   <= 1'b1;
                        if (idx == n) iss_done <= 1'b1;
                        else          idx      <= idx + ADDR_W'(1);
                    end
                    if (pend) begin
                        acc <= sum_next;
                        if (rcv == n) begin
                            state   <= (state == S_ACC_X) ? S_DIV_X : S_DIV_Y;
                            div_neg <= div_in[RES_W-1];
                            div_q   <= div_mag;
                            div_rem <= '0;
                            div_cnt <= '0;
                        end else begin
                            rcv <= rcv + ADDR_W'(1);
                        end
                    end
                end
                S_ACC_C: begin
                    // Reads alternate X[i], Y[i]; dx is held until its Y partner arrives.
                    if (!iss_done) begin
                        issue <= 1'b1;
                        phase <= ~phase;
                        if (!phase) begin
                            rd_addr <= idx;
                        end else begin
                            rd_addr <= n + idx;
                            issue_y <= 1'b1;
                            if (idx == n) iss_done <= 1'b1;
                            else          idx      <= idx + ADDR_W'(1);
                        end
                    end
                    if (pend) begin
                        if (!pend_y) begin
                            dx <= samp - x_bar;
                        end else begin
                            acc <= c_next;
                            if (rcv == n) begin
                                state   <= S_DIV_C;
                                div_neg <= div_in[RES_W-1];
                                div_q   <= div_mag;
                                div_rem <= '0;
                                div_cnt <= '0;
                            end else begin
                                rcv <= rcv + ADDR_W'(1);
                            end
                        end
                    end
                end
                S_DIV_X, S_DIV_Y, S_DIV_C: begin
                    div_q   <= q_next;
                    div_rem <= rem_next;
                    div_cnt <= div_cnt + CNT_W'(1);
                    if (div_last) begin
                        acc      <= '0;
                        idx      <= ADDR_W'(1);
                        rcv      <= ADDR_W'(1);
                        iss_done <= 1'b0;
                        phase    <= 1'b0;
                        case (state)
                            S_DIV_X: begin
                                x_bar <= q_signed;
                                state <= S_ACC_Y;
                            end
                            S_DIV_Y: begin
                                y_bar <= q_signed;
                                state <= S_ACC_C;
                            end
                            default: begin
                                result <= q_signed;
                                state  <= S_WR_HI;
                            end
                        endcase
                    end
                end
                S_WR_HI: state <= S_WR_LO;
                S_WR_LO: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cov_engine.md
COV_ENGINE -- requirements
Module: cov_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width in bits (unsigned integer samples).
REQ-002 SHALL have parameter FRAC_W, default 8, meaning fractional bits of the fixed-point result; RES_W = DATA_W+FRAC_W.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning data-memory address width; N and all addresses are ADDR_W bits.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clk  input  1  system clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 Start  input  1  launch request (level).
REQ-008 Ack  output  1  run complete (level).
REQ-009 MemRdAddr  output  ADDR_W  data-memory read address.
REQ-010 MemRdData  input  DATA_W  read data, valid exactly 1 cycle after MemRdAddr.
REQ-011 MemWrEn, MemWrAddr, MemWrData  output  1/ADDR_W/DATA_W  single-port write strobe, address, data.

Function
REQ-012 Memory layout: mem[0]=N; X[i] at 1..N; Y[i] at N+1..2N; result high byte at 2N+1, low byte at 2N+2 (DATA_W=8; otherwise result split into RES_W/DATA_W words, MSW first).
REQ-013 States: IDLE, ARM, RD_N, ACC_X, DIV_X, ACC_Y, DIV_Y, ACC_C, DIV_C, WR_HI, WR_LO, DONE.
REQ-014 IDLE/DONE with Start=1 -> ARM, Ack cleared next cycle; ARM with Start=0 -> RD_N (run begins on Start deassertion).
REQ-015 Start asserted in any other state SHALL be ignored.
REQ-016 Mean: sum of (X[i]<<FRAC_W) over i=1..N, wrapping mod 2^RES_W, interpreted signed, divided by N -> x_bar; same for Y -> y_bar.
REQ-017 Covariance term: t_i = ((X[i]<<FRAC_W)-x_bar)*((Y[i]<<FRAC_W)-y_bar) as 2*RES_W signed product, arithmetic right shift FRAC_W, truncated to RES_W; terms summed mod 2^RES_W (see REQ-027); sum/N is the result.
REQ-018 All divisions: signed dividend by unsigned N, quotient truncated toward zero, low RES_W bits kept.
REQ-019 Divider SHALL be iterative, one quotient bit per cycle (RES_W cycles per DIV_* state); no combinational divider.
REQ-020 ACC_C SHALL read X[i] and Y[i] per sample (two reads); no sample buffering.
REQ-021 WR_HI writes result[RES_W-1:DATA_W] to 2N+1; WR_LO writes result[DATA_W-1:0] to 2N+2; one write per cycle, MemWrEn high only in these states.
REQ-022 DONE: Ack=1, held until Start=1 (REQ-014) or Reset.
REQ-023 N=0: RD_N SHALL go directly to WR_HI with result 0, writing addresses 1 and 2; no divide.
REQ-024 Addresses wrap mod 2^ADDR_W; no error for 2N+2 overflow.

Reset
REQ-025 Reset=1 at any clock edge, including mid-run: state IDLE, Ack=0, MemWrEn=0, MemRdAddr=0, MemWrAddr=0, MemWrData=0, accumulators/divider cleared; no further memory writes from the aborted run.
REQ-026 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-027 Macro COV_SATURATE_EN: defined -> covariance sum in ACC_C clamps to [-2^(RES_W-1), 2^(RES_W-1)-1] on each add; undefined -> wraps mod 2^RES_W. Mean sums always wrap.

Verification
REQ-028 N=3, X={1,2,3}, Y={10,20,27}, Start high 2 cycles then low -> Ack rises; mem[7]=0x05, mem[8]=0xAA (x_bar 0x0200, y_bar 0x1300).
REQ-029 Then Start pulse, N=4, X={2,4,8,10}, Y={7,3,5,1} -> mem[9]=0xFB, mem[10]=0x00 (negative quotient, truncation toward zero).
REQ-030 N=0 -> Ack within 5 cycles of run start; mem[1]=0x00, mem[2]=0x00.
REQ-031 N=2, X={0,20}, Y={0,20} -> without COV_SATURATE_EN mem[5..6]=0xE4,0x00; with it 0x3F,0xFF.
REQ-032 Reset asserted during DIV_Y of the REQ-028 run -> Ack stays 0, MemWrEn never asserts, mem[7..8] unchanged; subsequent Start pulse completes with REQ-028 values.
REQ-033 Start re-asserted during ACC_X -> ignored; run completes with correct result and single Ack.
